// File: rtl/id_ex_latch_pkg.sv
// Shared widths and encodings for the ID/EX pipeline register and its neighbours.
package id_ex_latch_pkg;
  localparam int DATA_SIZE      = 32;
  localparam int REG_ADDR_SIZE  = 5;
  localparam int OPCODE_SIZE    = 6;
  localparam int FUNC_CODE_SIZE = 6;

  localparam logic [OPCODE_SIZE-1:0]    RTYPE_OPCODE = 6'b000000;
  localparam logic [FUNC_CODE_SIZE-1:0] SLL_FCODE    = 6'b000000;

  typedef enum logic [1:0] {
    BHW_BYTE = 2'b00,
    BHW_HALF = 2'b01,
    BHW_WORD = 2'b10
  } bhw_e;
endpackage

// File: rtl/id_ex_latch_pipe_reg.sv
// Generic pipeline register: async reset, hold on !i_enable, synchronous clear to zero.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      data_q <= '0;
    else if (i_enable) begin
      if (i_clear)
        data_q <= '0;
      else
        data_q <= i_d;
    end
  end

  assign o_q = data_q;
endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: one-cycle capture of decoded operands and control,
// with freeze (hold) and bubble (canonical SLL r0 NOP, o_valid=0).
module id_ex_latch
  import id_ex_latch_pkg::*;
#(
  parameter int DATA_SIZE_P      = DATA_SIZE,
  parameter int REG_ADDR_SIZE_P  = REG_ADDR_SIZE,
  parameter int OPCODE_SIZE_P    = OPCODE_SIZE,
  parameter int FUNC_CODE_SIZE_P = FUNC_CODE_SIZE
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_flush,
  input  logic [DATA_SIZE_P-1:0]      i_pc_plus4,
  input  logic [DATA_SIZE_P-1:0]      i_data_a,
  input  logic [DATA_SIZE_P-1:0]      i_data_b,
  input  logic [DATA_SIZE_P-1:0]      i_immediate,
  input  logic [REG_ADDR_SIZE_P-1:0]  i_shamt,
  input  logic [REG_ADDR_SIZE_P-1:0]  i_rs,
  input  logic [REG_ADDR_SIZE_P-1:0]  i_rt,
  input  logic [REG_ADDR_SIZE_P-1:0]  i_rd,
  input  logic [OPCODE_SIZE_P-1:0]    i_opcode,
  input  logic [FUNC_CODE_SIZE_P-1:0] i_funct_code,
  input  logic                        i_reg_dst,
  input  logic                        i_alu_src,
  input  logic                        i_mem_read,
  input  logic                        i_mem_write,
  input  logic                        i_mem_to_reg,
  input  logic                        i_reg_write,
  input  logic                        i_signed,
  input  logic                        i_halt,
  input  logic [1:0]                  i_bhw_type,
  output logic [DATA_SIZE_P-1:0]      o_pc_plus4,
  output logic [DATA_SIZE_P-1:0]      o_data_a,
  output logic [DATA_SIZE_P-1:0]      o_data_b,
  output logic [DATA_SIZE_P-1:0]      o_immediate,
  output logic [REG_ADDR_SIZE_P-1:0]  o_shamt,
  output logic [REG_ADDR_SIZE_P-1:0]  o_rs,
  output logic [REG_ADDR_SIZE_P-1:0]  o_rt,
  output logic [REG_ADDR_SIZE_P-1:0]  o_rd,
  output logic [OPCODE_SIZE_P-1:0]    o_opcode,
  output logic [FUNC_CODE_SIZE_P-1:0] o_funct_code,
  output logic                        o_reg_dst,
  output logic                        o_alu_src,
  output logic                        o_mem_read,
  output logic                        o_mem_write,
  output logic                        o_mem_to_reg,
  output logic                        o_reg_write,
  output logic                        o_signed,
  output logic                        o_halt,
  output logic [1:0]                  o_bhw_type,
  output logic                        o_valid
);
  localparam int DATA_W = 4 * DATA_SIZE_P;
  localparam int REGS_W = 4 * REG_ADDR_SIZE_P;
  localparam int OP_W   = OPCODE_SIZE_P + FUNC_CODE_SIZE_P;
  localparam int CTRL_W = 8 + 2 + 1;

  localparam logic [OPCODE_SIZE_P-1:0]    BUBBLE_OP = OPCODE_SIZE_P'(RTYPE_OPCODE);
  localparam logic [FUNC_CODE_SIZE_P-1:0] BUBBLE_FN = FUNC_CODE_SIZE_P'(SLL_FCODE);

  logic [DATA_W-1:0] data_d, data_q;
  logic [REGS_W-1:0] regs_d, regs_q;
  logic [OP_W-1:0]   op_d,   op_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  assign data_d = {i_pc_plus4, i_data_a, i_data_b, i_immediate};
  assign regs_d = {i_shamt, i_rs, i_rt, i_rd};
  // Bubble opcode/funct are injected here rather than cleared, so a non-zero NOP encoding still works.
  assign op_d   = i_flush ? {BUBBLE_OP, BUBBLE_FN} : {i_opcode, i_funct_code};
  assign ctrl_d = {i_reg_dst, i_alu_src, i_mem_read, i_mem_write, i_mem_to_reg,
                   i_reg_write, i_signed, i_halt, i_bhw_type, 1'b1};

  pipe_reg #(.WIDTH(DATA_W)) u_data (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_flush),
    .i_d(data_d), .o_q(data_q)
  );

  pipe_reg #(.WIDTH(REGS_W)) u_regs (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_flush),
    .i_d(regs_d), .o_q(regs_q)
  );

  pipe_reg #(.WIDTH(OP_W)) u_op (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(1'b0),
    .i_d(op_d), .o_q(op_q)
  );

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_flush),
    .i_d(ctrl_d), .o_q(ctrl_q)
  );

  assign {o_pc_plus4, o_data_a, o_data_b, o_immediate} = data_q;
  assign {o_shamt, o_rs, o_rt, o_rd}                   = regs_q;
  assign {o_opcode, o_funct_code}                      = op_q;
  assign {o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg,
          o_reg_write, o_signed, o_halt, o_bhw_type, o_valid} = ctrl_q;
endmodule

// File: tb/tb_id_ex_latch.sv
// Bench for id_ex_latch: directed scenarios plus randomized enable/flush/reset against a field-level model.
module tb_id_ex_latch;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        sgn;
    logic        halt;
    logic [1:0]  bhw;
    logic        valid;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    en = 1'b0;
  logic    flush = 1'b0;
  fields_t in_s = '0;
  fields_t exp_s = '0;
  fields_t dut_s;
  int      errors = 0;
  int      checks = 0;

  logic [31:0] o_pc, o_a, o_b, o_imm;
  logic [4:0]  o_shamt, o_rs, o_rt, o_rd;
  logic [5:0]  o_op, o_fn;
  logic        o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg;
  logic        o_reg_write, o_sgn, o_halt, o_valid;
  logic [1:0]  o_bhw;

  always #5 clk = ~clk;

  id_ex_latch dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(flush),
    .i_pc_plus4(in_s.pc), .i_data_a(in_s.a), .i_data_b(in_s.b), .i_immediate(in_s.imm),
    .i_shamt(in_s.shamt), .i_rs(in_s.rs), .i_rt(in_s.rt), .i_rd(in_s.rd),
    .i_opcode(in_s.op), .i_funct_code(in_s.fn),
    .i_reg_dst(in_s.reg_dst), .i_alu_src(in_s.alu_src), .i_mem_read(in_s.mem_read),
    .i_mem_write(in_s.mem_write), .i_mem_to_reg(in_s.mem_to_reg), .i_reg_write(in_s.reg_write),
    .i_signed(in_s.sgn), .i_halt(in_s.halt), .i_bhw_type(in_s.bhw),
    .o_pc_plus4(o_pc), .o_data_a(o_a), .o_data_b(o_b), .o_immediate(o_imm),
    .o_shamt(o_shamt), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_opcode(o_op), .o_funct_code(o_fn),
    .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_signed(o_sgn), .o_halt(o_halt), .o_bhw_type(o_bhw), .o_valid(o_valid)
  );

  assign dut_s = {o_pc, o_a, o_b, o_imm, o_shamt, o_rs, o_rt, o_rd, o_op, o_fn,
                  o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg,
                  o_reg_write, o_sgn, o_halt, o_bhw, o_valid};

  // Bubble and reset image: SLL r0,r0,0 with everything else zero.
  function automatic fields_t bubble_img();
    fields_t f = '0;
    f.op = 6'h00;
    f.fn = 6'h00;
    return f;
  endfunction

  task automatic check_all(input string nm);
    checks++;
    if (dut_s !== exp_s) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, dut_s, exp_s);
    end
  endtask

  task automatic check_lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, want);
    end
  endtask

  // Advance one clock: model follows reset > hold > bubble > load; compare on the falling edge.
  task automatic step(input string nm);
    @(posedge clk);
    if (rst)         exp_s = '0;
    else if (!en)    exp_s = exp_s;
    else if (flush)  exp_s = bubble_img();
    else begin
      exp_s = in_s;
      exp_s.valid = 1'b1;
    end
    @(negedge clk);
    check_all(nm);
  endtask

  task automatic rand_inputs();
    in_s.pc = $urandom; in_s.a = $urandom; in_s.b = $urandom; in_s.imm = $urandom;
    in_s.shamt = 5'($urandom); in_s.rs = 5'($urandom); in_s.rt = 5'($urandom); in_s.rd = 5'($urandom);
    in_s.op = 6'($urandom); in_s.fn = 6'($urandom);
    {in_s.reg_dst, in_s.alu_src, in_s.mem_read, in_s.mem_write,
     in_s.mem_to_reg, in_s.reg_write, in_s.sgn, in_s.halt} = 8'($urandom);
    in_s.bhw = 2'($urandom_range(0, 2));
    in_s.valid = 1'b0;
  endtask

  int mw_count, mr_count;

  initial begin
    @(negedge clk);
    check_all("reset_state");
    check_lit("reset_valid", 32'(o_valid), 32'd0);
    rst = 1'b0;

    // Load an ADDI with data_a=0xFF.
    rand_inputs();
    en = 1'b1; flush = 1'b0;
    in_s.a = 32'h0000_00FF; in_s.op = 6'h08; in_s.reg_write = 1'b1;
    step("load_addi");
    check_lit("addi_data_a", o_a, 32'h0000_00FF);
    check_lit("addi_opcode", 32'(o_op), 32'h08);
    check_lit("addi_valid", 32'(o_valid), 32'd1);

    // Async reset mid-cycle with data loaded.
    rand_inputs();
    #2 rst = 1'b1;
    #1;
    exp_s = '0;
    check_all("async_reset");
    check_lit("async_reset_valid", 32'(o_valid), 32'd0);
    step("reset_held");
    rst = 1'b0;

    // Loaded state then a one-cycle flush.
    rand_inputs();
    in_s.reg_write = 1'b1; in_s.mem_write = 1'b1; in_s.rd = 5'd9;
    step("load_before_flush");
    flush = 1'b1;
    step("flush");
    check_lit("flush_reg_write", 32'(o_reg_write), 32'd0);
    check_lit("flush_mem_write", 32'(o_mem_write), 32'd0);
    check_lit("flush_opcode", 32'(o_op), 32'd0);
    check_lit("flush_funct", 32'(o_fn), 32'd0);
    check_lit("flush_rd", 32'(o_rd), 32'd0);
    check_lit("flush_valid", 32'(o_valid), 32'd0);

    // Freeze for 3 cycles with toggling inputs and flush asserted.
    flush = 1'b0;
    rand_inputs();
    step("load_before_freeze");
    en = 1'b0; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step("freeze_hold");
      check_lit("freeze_valid", 32'(o_valid), 32'd1);
    end
    en = 1'b1; flush = 1'b0;
    rand_inputs();
    step("resume_load");
    check_lit("resume_pc", o_pc, in_s.pc);

    // SW, bubble, LW.
    mw_count = 0; mr_count = 0;
    rand_inputs();
    in_s.op = 6'h2B; in_s.mem_write = 1'b1; in_s.mem_read = 1'b0; in_s.bhw = 2'b10;
    step("sw");
    check_lit("sw_mem_write", 32'(o_mem_write), 32'd1);
    mw_count += int'(o_mem_write); mr_count += int'(o_mem_read);
    flush = 1'b1;
    step("sw_lw_bubble");
    mw_count += int'(o_mem_write); mr_count += int'(o_mem_read);
    flush = 1'b0;
    rand_inputs();
    in_s.op = 6'h23; in_s.mem_read = 1'b1; in_s.mem_write = 1'b0;
    step("lw");
    check_lit("lw_mem_read", 32'(o_mem_read), 32'd1);
    mw_count += int'(o_mem_write); mr_count += int'(o_mem_read);
    check_lit("mem_write_cycles", 32'(mw_count), 32'd1);
    check_lit("mem_read_cycles", 32'(mr_count), 32'd1);

    // Random enable/flush/reset.
    for (int i = 0; i < 10000; i++) begin
      rand_inputs();
      en    = ($urandom_range(0, 99) < 80);
      flush = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 3) begin
        #2 rst = 1'b1;
        #1;
        exp_s = '0;
        check_all("rand_async_reset");
      end else begin
        rst = 1'b0;
      end
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
